// File: rtl/video_axis_pkg.sv
// rtl/video_axis_pkg.sv - shared encodings, LFSR constants and FSM state type for the video stream checker
package video_axis_pkg;

    // Backpressure pattern select
    localparam logic [1:0] BP_ALWAYS = 2'd0;
    localparam logic [1:0] BP_TOGGLE = 2'd1;
    localparam logic [1:0] BP_LFSR   = 2'd2;
    localparam logic [1:0] BP_NEVER  = 2'd3;

    // x^16+x^14+x^13+x^11+1 as a right-shifting Fibonacci LFSR: feedback taps on bits 0,2,3,5
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } chk_state_e;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/axis_video_checker_if.sv
// rtl/axis_video_checker_if.sv - video stream bundle with source and sink views
interface axis_video_checker_if #(
    parameter int DATA_W = 24
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tuser;
    logic              tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/axis_bp_gen.sv
// rtl/axis_bp_gen.sv - registered tready pattern generator for sink backpressure
module axis_bp_gen
    import video_axis_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] bp_mode,
    output logic       tready
);

    logic [15:0] lfsr_q, lfsr_d;
    logic        armed_q;
    logic        tready_q, tready_d;

    // Next tready per mode; held low until one edge after reset release has passed
    always_comb begin
        lfsr_d   = lfsr_step(lfsr_q);
        tready_d = 1'b0;
        case (bp_mode)
            BP_ALWAYS: tready_d = 1'b1;
            BP_TOGGLE: tready_d = ~tready_q;
            BP_LFSR:   tready_d = lfsr_q[0];
            BP_NEVER:  tready_d = 1'b0;
            default:   tready_d = 1'b0;
        endcase
        if (!armed_q) begin
            tready_d = 1'b0;
        end
    end

    // State registers; the LFSR free-runs every cycle regardless of mode
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr_q   <= LFSR_SEED;
            armed_q  <= 1'b0;
            tready_q <= 1'b0;
        end else begin
            lfsr_q   <= lfsr_d;
            armed_q  <= 1'b1;
            tready_q <= tready_d;
        end
    end

    assign tready = tready_q;

endmodule

// File: rtl/axis_video_checker.sv
// rtl/axis_video_checker.sv - video stream framing checker with frame sum, counters and sticky errors
module axis_video_checker
    import video_axis_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int DATA_W   = 24
) (
    input  logic                  clk,
    input  logic                  rstn,
    axis_video_checker_if.slave   s_axis_video,
    input  logic [1:0]            bp_mode,
    input  logic                  err_clr,
    output logic                  frame_done,
    output logic [15:0]           frame_cnt,
    output logic [31:0]           frame_sum,
    output logic                  err_eol_early,
    output logic                  err_eol_late,
    output logic                  err_sof_early,
    output logic [15:0]           drop_cnt
);

    // pix must be able to hold H_ACTIVE itself (saturation value)
    localparam int PIX_W  = $clog2(H_ACTIVE + 1);
    localparam int LINE_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

    logic              tready_w;
    logic              beat;
    logic [DATA_W-1:0] pix_data;

    chk_state_e        state_q, state_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [31:0]       sum_q, sum_d;
    logic              late_q, late_d;
    logic [15:0]       drop_q, drop_d;
    logic              eol_early_q, eol_early_d;
    logic              eol_late_q, eol_late_d;
    logic              sof_early_q, sof_early_d;
    logic              done_q, done_d;
    logic [15:0]       fcnt_q, fcnt_d;
    logic [31:0]       fsum_q, fsum_d;

    logic [PIX_W-1:0]  cur_pix;
    logic [PIX_W:0]    pix_inc;
    logic [LINE_W-1:0] cur_line;
    logic [31:0]       cur_sum;
    logic              cur_late;

    axis_bp_gen u_bp_gen (
        .clk     (clk),
        .rstn    (rstn),
        .bp_mode (bp_mode),
        .tready  (tready_w)
    );

    assign s_axis_video.tready = tready_w;
    assign pix_data            = s_axis_video.tdata;
    assign beat                = s_axis_video.tvalid & tready_w;

    // Frame FSM and datapath next state; a SOF beat starts from zeroed counters then runs the common pixel/EOL path
    always_comb begin
        state_d     = state_q;
        pix_d       = pix_q;
        line_d      = line_q;
        sum_d       = sum_q;
        late_d      = late_q;
        drop_d      = drop_q;
        eol_early_d = eol_early_q & ~err_clr;
        eol_late_d  = eol_late_q & ~err_clr;
        sof_early_d = sof_early_q & ~err_clr;
        done_d      = 1'b0;
        fcnt_d      = fcnt_q;
        fsum_d      = fsum_q;
        cur_pix     = s_axis_video.tuser ? '0 : pix_q;
        cur_line    = s_axis_video.tuser ? '0 : line_q;
        cur_sum     = s_axis_video.tuser ? '0 : sum_q;
        cur_late    = s_axis_video.tuser ? 1'b0 : late_q;
        pix_inc     = {1'b0, cur_pix} + (PIX_W+1)'(1);

        if (beat) begin
            if (state_q == WAIT_SOF && !s_axis_video.tuser) begin
                if (drop_q != 16'hFFFF) begin
                    drop_d = drop_q + 16'd1;
                end
            end else begin
                if (state_q == ACTIVE && s_axis_video.tuser) begin
                    sof_early_d = 1'b1;
                end
                state_d = ACTIVE;
                sum_d   = cur_sum + 32'(pix_data);
                if (s_axis_video.tlast) begin
                    if (pix_inc < (PIX_W+1)'(H_ACTIVE)) begin
                        eol_early_d = 1'b1;
                    end
                    pix_d  = '0;
                    late_d = 1'b0;
                    if (cur_line == LINE_W'(V_ACTIVE - 1)) begin
                        done_d  = 1'b1;
                        fcnt_d  = fcnt_q + 16'd1;
                        fsum_d  = sum_d;
                        line_d  = '0;
                        state_d = WAIT_SOF;
                    end else begin
                        line_d = cur_line + LINE_W'(1);
                    end
                end else begin
                    line_d = cur_line;
                    if (pix_inc >= (PIX_W+1)'(H_ACTIVE)) begin
                        pix_d  = PIX_W'(H_ACTIVE);
                        late_d = 1'b1;
                        if (!cur_late) begin
                            eol_late_d = 1'b1;
                        end
                    end else begin
                        pix_d  = pix_inc[PIX_W-1:0];
                        late_d = cur_late;
                    end
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= WAIT_SOF;
            pix_q       <= '0;
            line_q      <= '0;
            sum_q       <= '0;
            late_q      <= 1'b0;
            drop_q      <= '0;
            eol_early_q <= 1'b0;
            eol_late_q  <= 1'b0;
            sof_early_q <= 1'b0;
            done_q      <= 1'b0;
            fcnt_q      <= '0;
            fsum_q      <= '0;
        end else begin
            state_q     <= state_d;
            pix_q       <= pix_d;
            line_q      <= line_d;
            sum_q       <= sum_d;
            late_q      <= late_d;
            drop_q      <= drop_d;
            eol_early_q <= eol_early_d;
            eol_late_q  <= eol_late_d;
            sof_early_q <= sof_early_d;
            done_q      <= done_d;
            fcnt_q      <= fcnt_d;
            fsum_q      <= fsum_d;
        end
    end

    assign frame_done    = done_q;
    assign frame_cnt     = fcnt_q;
    assign frame_sum     = fsum_q;
    assign err_eol_early = eol_early_q;
    assign err_eol_late  = eol_late_q;
    assign err_sof_early = sof_early_q;
    assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_axis_video_checker.sv
// tb/tb_axis_video_checker.sv - scoreboard bench for the video stream checker
module tb_axis_video_checker;

    localparam int H  = 16;
    localparam int V  = 4;
    localparam int DW = 24;

    typedef struct {
        logic [31:0] sum;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [1:0]  bp_mode = 2'd0;
    logic        err_clr = 1'b0;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic [31:0] frame_sum;
    logic        err_eol_early;
    logic        err_eol_late;
    logic        err_sof_early;
    logic [15:0] drop_cnt;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    logic [15:0] model_cnt = '0;
    logic [31:0] acc = '0;
    bit          seen_low = 0;

    always #5 clk = ~clk;

    axis_video_checker_if #(.DATA_W(DW)) vif ();

    axis_video_checker #(.H_ACTIVE(H), .V_ACTIVE(V), .DATA_W(DW)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_axis_video  (vif),
        .bp_mode       (bp_mode),
        .err_clr       (err_clr),
        .frame_done    (frame_done),
        .frame_cnt     (frame_cnt),
        .frame_sum     (frame_sum),
        .err_eol_early (err_eol_early),
        .err_eol_late  (err_eol_late),
        .err_sof_early (err_sof_early),
        .drop_cnt      (drop_cnt)
    );

    initial begin
        vif.tdata  = '0;
        vif.tvalid = 1'b0;
        vif.tuser  = 1'b0;
        vif.tlast  = 1'b0;
    end

    // Scoreboard consumer: every frame_done pulse must match the oldest expected frame
    always @(negedge clk) begin
        exp_t e;
        if (rstn && frame_done) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame_done frame_cnt=%0d frame_sum=%0d, no frame expected", frame_cnt, frame_sum);
            end else begin
                e = sb.pop_front();
                if (frame_sum !== e.sum || frame_cnt !== e.cnt) begin
                    errors++;
                    $display("FAIL frame_result sum=%0d cnt=%0d, expected sum=%0d cnt=%0d", frame_sum, frame_cnt, e.sum, e.cnt);
                end
            end
        end
    end

    task automatic send_beat(input int d, input bit u, input bit l);
        int n;
        vif.tdata  = DW'(d);
        vif.tuser  = u;
        vif.tlast  = l;
        vif.tvalid = 1'b1;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (vif.tready === 1'b1) break;
            seen_low = 1;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL beat_timeout tready stayed %b for %0d cycles, expected 1", vif.tready, n);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (u) acc = 32'(DW'(d));
        else   acc = acc + 32'(DW'(d));
        vif.tvalid = 1'b0;
        vif.tuser  = 1'b0;
        vif.tlast  = 1'b0;
    endtask

    task automatic send_line(input int base, input int n, input bit sof);
        for (int i = 0; i < n; i++) begin
            send_beat(base + i, sof && (i == 0), i == n - 1);
        end
    endtask

    task automatic expect_frame();
        exp_t e;
        model_cnt = model_cnt + 16'd1;
        e.sum = acc;
        e.cnt = model_cnt;
        sb.push_back(e);
    endtask

    task automatic send_frame(input int base);
        for (int l = 0; l < V; l++) begin
            send_line(base + l * H, H, l == 0);
        end
        expect_frame();
    endtask

    task automatic do_reset(input logic [1:0] mode);
        rstn = 1'b0;
        bp_mode = mode;
        err_clr = 1'b0;
        vif.tvalid = 1'b0;
        sb.delete();
        model_cnt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset(2'd0);
        checks++;
        if ({frame_done, frame_cnt, frame_sum, drop_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_counters done=%b cnt=%0d sum=%0d drop=%0d, expected all 0", frame_done, frame_cnt, frame_sum, drop_cnt);
        end
        checks++;
        if ({err_eol_early, err_eol_late, err_sof_early} !== 3'b000) begin
            errors++;
            $display("FAIL reset_errs flags=%b, expected 000", {err_eol_early, err_eol_late, err_sof_early});
        end
        @(negedge clk);
        checks++;
        if (vif.tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_tready_first_edge tready=%b, expected 0", vif.tready);
        end
        @(negedge clk);
        checks++;
        if (vif.tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_tready_second_edge tready=%b, expected 1", vif.tready);
        end
    endtask

    task automatic test_mode0_frame();
        do_reset(2'd0);
        send_frame(0);
        settle();
        checks++;
        if (frame_cnt !== 16'd1 || frame_sum !== 32'd2016) begin
            errors++;
            $display("FAIL mode0_frame cnt=%0d sum=%0d, expected cnt=1 sum=2016", frame_cnt, frame_sum);
        end
        checks++;
        if ({err_eol_early, err_eol_late, err_sof_early} !== 3'b000 || drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL mode0_clean flags=%b drop=%0d, expected 000 and 0", {err_eol_early, err_eol_late, err_sof_early}, drop_cnt);
        end
    endtask

    task automatic test_lfsr_backpressure();
        bit hi;
        do_reset(2'd2);
        seen_low = 0;
        send_frame(0);
        settle();
        checks++;
        if (frame_cnt !== 16'd1 || frame_sum !== 32'd2016) begin
            errors++;
            $display("FAIL lfsr_frame cnt=%0d sum=%0d, expected cnt=1 sum=2016", frame_cnt, frame_sum);
        end
        checks++;
        if (seen_low !== 1'b1) begin
            errors++;
            $display("FAIL lfsr_stall seen_low=%b, expected 1", seen_low);
        end
        bp_mode = 2'd3;
        repeat (2) @(negedge clk);
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (vif.tready !== 1'b0) hi = 1;
        end
        checks++;
        if (hi !== 1'b0) begin
            errors++;
            $display("FAIL never_ready tready_high_seen=%b, expected 0", hi);
        end
    endtask

    task automatic test_drop();
        do_reset(2'd0);
        for (int i = 0; i < 5; i++) begin
            send_beat(100 + i, 1'b0, 1'b0);
        end
        send_frame(0);
        settle();
        checks++;
        if (drop_cnt !== 16'd5 || frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL drop drop=%0d cnt=%0d, expected drop=5 cnt=1", drop_cnt, frame_cnt);
        end
    endtask

    task automatic test_eol_early();
        do_reset(2'd0);
        send_line(0, H, 1'b1);
        send_line(16, 10, 1'b0);
        send_line(26, H, 1'b0);
        send_line(42, H, 1'b0);
        expect_frame();
        settle();
        checks++;
        if ({err_eol_early, err_eol_late, err_sof_early} !== 3'b100 || frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL eol_early flags=%b cnt=%0d, expected 100 cnt=1", {err_eol_early, err_eol_late, err_sof_early}, frame_cnt);
        end
        send_frame(1000);
        settle();
        checks++;
        if (frame_cnt !== 16'd2) begin
            errors++;
            $display("FAIL eol_early_next cnt=%0d, expected 2", frame_cnt);
        end
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (err_eol_early !== 1'b0) begin
            errors++;
            $display("FAIL eol_early_clear flag=%b, expected 0", err_eol_early);
        end
    endtask

    task automatic test_eol_late_clr_collision();
        do_reset(2'd0);
        for (int i = 0; i < 15; i++) begin
            send_beat(i, i == 0, 1'b0);
        end
        err_clr = 1'b1;
        send_beat(15, 1'b0, 1'b0);
        err_clr = 1'b0;
        send_beat(16, 1'b0, 1'b1);
        for (int l = 1; l < V; l++) begin
            send_line(100 + l * H, H, 1'b0);
        end
        expect_frame();
        settle();
        checks++;
        if ({err_eol_early, err_eol_late, err_sof_early} !== 3'b010 || frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL eol_late_vs_clr flags=%b cnt=%0d, expected 010 cnt=1", {err_eol_early, err_eol_late, err_sof_early}, frame_cnt);
        end
    endtask

    task automatic test_sof_early();
        do_reset(2'd0);
        send_line(0, H, 1'b1);
        send_line(16, H, 1'b0);
        send_frame(500);
        settle();
        checks++;
        if ({err_eol_early, err_eol_late, err_sof_early} !== 3'b001 || frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL sof_early flags=%b cnt=%0d, expected 001 cnt=1", {err_eol_early, err_eol_late, err_sof_early}, frame_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset(2'd0);
        send_line(0, H, 1'b1);
        send_line(16, H, 1'b0);
        for (int i = 0; i < 5; i++) begin
            send_beat(32 + i, 1'b0, 1'b0);
        end
        rstn = 1'b0;
        sb.delete();
        model_cnt = '0;
        #1;
        checks++;
        if ({frame_done, frame_cnt, frame_sum, drop_cnt, vif.tready, err_eol_early, err_eol_late, err_sof_early} !== '0) begin
            errors++;
            $display("FAIL mid_reset done=%b cnt=%0d sum=%0d drop=%0d tready=%b, expected all 0", frame_done, frame_cnt, frame_sum, drop_cnt, vif.tready);
        end
        @(negedge clk);
        rstn = 1'b1;
        send_frame(7);
        settle();
        checks++;
        if (frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL mid_reset_next cnt=%0d, expected 1", frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_mode0_frame();
        test_lfsr_backpressure();
        test_drop();
        test_eol_early();
        test_eol_late_clr_collision();
        test_sof_early();
        test_reset_mid_frame();
        settle();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_video_checker.md
AXIS_VIDEO_CHECKER -- requirements
Module: axis_video_checker

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, lines per frame.
REQ-003 SHALL have parameter DATA_W, default 24, pixel width.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 s_axis_video_tdata  input  DATA_W  pixel data.
REQ-007 s_axis_video_tvalid  input  1  source beat valid.
REQ-008 s_axis_video_tready  output  1  sink ready, registered.
REQ-009 s_axis_video_tuser  input  1  start of frame, on first pixel.
REQ-010 s_axis_video_tlast  input  1  end of line, on last pixel.
REQ-011 bp_mode  input  2  backpressure: 0 always ready, 1 every other cycle, 2 LFSR pseudo-random, 3 never ready.
REQ-012 err_clr  input  1  single-cycle clear of sticky error flags.
REQ-013 frame_done  output  1  one-cycle pulse on completed frame.
REQ-014 frame_cnt  output  16  completed frames, wraps.
REQ-015 frame_sum  output  32  mod-2^32 sum of all tdata of the last completed frame.
REQ-016 err_eol_early / err_eol_late / err_sof_early  output  1 each  sticky framing errors.
REQ-017 drop_cnt  output  16  beats discarded while waiting for SOF, saturating.

Function
REQ-018 Beat SHALL be tvalid & tready on a rising clk edge; no other cycle changes counters.
REQ-019 tready SHALL be registered; in mode 1 it toggles every cycle; in mode 2 it equals bit 0 of a 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1) advanced every cycle.
REQ-020 FSM states SHALL be WAIT_SOF and ACTIVE; reset enters WAIT_SOF.
REQ-021 In WAIT_SOF, a beat without tuser SHALL increment drop_cnt (saturate at 16'hFFFF) and be discarded.
REQ-022 In WAIT_SOF, a beat with tuser SHALL set pix=1, line=0, running sum=tdata, and go ACTIVE; a beat that also has tlast SHALL be processed as an end of line per REQ-024 in the same cycle.
REQ-023 In ACTIVE, a beat with tuser SHALL set err_sof_early and restart the frame as in REQ-022 without pulsing frame_done.
REQ-024 On a tlast beat, when the pixel count including this beat is < H_ACTIVE, err_eol_early SHALL be set; line SHALL increment and pix reset to 0.
REQ-025 On a non-tlast beat that brings pix to H_ACTIVE or beyond, err_eol_late SHALL be set once per line; pix SHALL saturate at H_ACTIVE.
REQ-026 A tlast beat with line == V_ACTIVE-1 SHALL, on the following cycle, pulse frame_done, increment frame_cnt, and latch frame_sum (including this beat); FSM returns to WAIT_SOF.
REQ-027 Running sum SHALL add every ACTIVE beat's tdata zero-extended to 32 bits, wrapping.
REQ-028 Error flags SHALL clear on err_clr; an error event in the same cycle as err_clr SHALL win (flag stays 1).
REQ-029 Pixel and line counters SHALL be clog2-sized from H_ACTIVE and V_ACTIVE respectively.

Reset
REQ-030 On rstn low, asynchronously: tready=0, frame_done=0, frame_cnt=0, frame_sum=0, all err flags=0, drop_cnt=0, pix=0, line=0, LFSR=seed, FSM=WAIT_SOF.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame; frame_cnt and frame_sum SHALL NOT update.
REQ-032 The first tready=1 SHALL occur no earlier than the second clk edge after rstn deasserts.

Structure
REQ-033 bp_mode encodings, LFSR seed and taps SHALL be localparams in shared package video_axis_pkg.
REQ-034 The backpressure generator SHALL be sub-module axis_bp_gen (bp_mode in, tready out).
REQ-035 No memories; all state in flops.

Verification (H_ACTIVE=16, V_ACTIVE=4)
REQ-036 Mode 0, one frame of 4x16 beats with tdata=0..63, correct tuser/tlast -> one frame_done pulse, frame_cnt=1, frame_sum=2016, no errors.
REQ-037 Mode 2, same frame with the source holding tvalid through stalls -> identical frame_sum=2016, and tready observed low on at least one cycle.
REQ-038 5 beats without tuser, then a valid frame -> drop_cnt=5, frame_cnt=1.
REQ-039 tlast on beat 10 of line 1 -> err_eol_early=1; the next frame still completes; err_clr -> flag returns to 0.
REQ-040 tuser on line 2 of a frame -> err_sof_early=1, no frame_done for the aborted frame; the restarted frame gives frame_cnt=1.
REQ-041 rstn pulsed low mid-line 2 -> all outputs at reset values; a following clean frame gives frame_cnt=1.
